// File: rtl/accum_multi_pkg.sv
// Shared types for the multi-channel accumulator: operation codes and FSM states.
package accum_multi_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    CLR = 2'd2,
    RD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accum_alu.sv
// Combinational add/subtract of a zero-extended operand against one channel value,
// with carry/borrow detection and optional clamping.
module accum_alu #(
  parameter int ACCUM_WIDTH = 64,
  parameter int ADD_WIDTH   = 32,
  parameter int SATURATE    = 0
) (
  input  logic [ACCUM_WIDTH-1:0] chanVal_i,
  input  logic [ADD_WIDTH-1:0]   operand_i,
  input  logic                   isSub_i,
  output logic [ACCUM_WIDTH-1:0] result_o,
  output logic                   flag_o
);

  localparam int PAD = ACCUM_WIDTH - ADD_WIDTH + 1;

  logic [ACCUM_WIDTH:0] extOperand;
  logic [ACCUM_WIDTH:0] rawSum;

  // The extra top bit carries out on ADD and borrows on SUB, so one bit flags both cases.
  always_comb begin
    extOperand = {{PAD{1'b0}}, operand_i};
    if (isSub_i) begin
      rawSum = {1'b0, chanVal_i} - extOperand;
    end else begin
      rawSum = {1'b0, chanVal_i} + extOperand;
    end
    flag_o   = rawSum[ACCUM_WIDTH];
    result_o = rawSum[ACCUM_WIDTH-1:0];
    if (flag_o && (SATURATE != 0)) begin
      result_o = isSub_i ? '0 : '1;
    end
  end

endmodule

// File: rtl/accum_multi.sv
// Multi-channel accumulator behind a 4-phase en/done handshake; one operation
// per request, executed in a single EXEC cycle.
module accum_multi
  import accum_multi_pkg::*;
#(
  parameter int ACCUM_WIDTH = 64,
  parameter int ADD_WIDTH   = 32,
  parameter int NUM_CH      = 4,
  parameter int SATURATE    = 0,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   en,
  input  logic [1:0]             op,
  input  logic [CHW-1:0]         ch,
  input  logic [ADD_WIDTH-1:0]   add,
  output logic [ACCUM_WIDTH-1:0] accum,
  output logic                   done,
  output logic                   busy,
  output logic [NUM_CH-1:0]      ovf
);

  localparam logic [CHW:0] NUM_CH_C = (CHW + 1)'(NUM_CH);

  if (ADD_WIDTH > ACCUM_WIDTH) begin : gBadWidth
    $error("accum_multi: ADD_WIDTH must not exceed ACCUM_WIDTH");
  end
  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : gBadChannels
    $error("accum_multi: NUM_CH must be in 1..16");
  end

  state_e                 state_q, state_d;
  op_e                    opReg_q;
  logic [CHW-1:0]         chReg_q;
  logic [ADD_WIDTH-1:0]   addReg_q;
  logic [ACCUM_WIDTH-1:0] chan_q [NUM_CH];
  logic [ACCUM_WIDTH-1:0] chan_d [NUM_CH];
  logic [ACCUM_WIDTH-1:0] accum_q, accum_d;
  logic [NUM_CH-1:0]      ovf_q, ovf_d;

  logic                   capture;
  logic                   execute;
  logic                   chValid;
  logic [ACCUM_WIDTH-1:0] selVal;
  logic [ACCUM_WIDTH-1:0] aluResult;
  logic                   aluFlag;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE is left only once en is seen low, so a held request cannot restart from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == IDLE) && en;
    execute = (state_q == EXEC);
    done    = (state_q == DONE);
    busy    = (state_q == EXEC) || (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      opReg_q  <= ADD;
      chReg_q  <= '0;
      addReg_q <= '0;
    end else if (capture) begin
      opReg_q  <= op_e'(op);
      chReg_q  <= ch;
      addReg_q <= add;
    end
  end

  // Channel indices past NUM_CH are legal on the port but address no register.
  always_comb begin
    chValid = ({1'b0, chReg_q} < NUM_CH_C);
    selVal  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chReg_q == i[CHW-1:0]) selVal = chan_q[i];
    end
  end

  accum_alu #(
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .ADD_WIDTH   (ADD_WIDTH),
    .SATURATE    (SATURATE)
  ) u_alu (
    .chanVal_i (selVal),
    .operand_i (addReg_q),
    .isSub_i   (opReg_q == SUB),
    .result_o  (aluResult),
    .flag_o    (aluFlag)
  );

  always_comb begin
    chan_d  = chan_q;
    ovf_d   = ovf_q;
    accum_d = accum_q;
    if (execute) begin
      if (!chValid) begin
        accum_d = '0;
      end else begin
        case (opReg_q)
          ADD, SUB: accum_d = aluResult;
          CLR:      accum_d = '0;
          RD:       accum_d = selVal;
          default:  accum_d = accum_q;
        endcase
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (chValid && (chReg_q == i[CHW-1:0])) begin
          case (opReg_q)
            ADD, SUB: begin
              chan_d[i] = aluResult;
              if (aluFlag) ovf_d[i] = 1'b1;
            end
            CLR: begin
              chan_d[i] = '0;
              ovf_d[i]  = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= '0;
      accum_q <= '0;
      ovf_q   <= '0;
    end else begin
      chan_q  <= chan_d;
      accum_q <= accum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign accum = accum_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_accum_multi.sv
// Scoreboard bench for accum_multi: three instances (default, 16-bit clamping,
// 16-bit wrapping with three channels) driven by directed requests.
module tb_accum_multi;
  import accum_multi_pkg::*;

  typedef struct {
    int          dutIdx;
    logic [63:0] accum;
    logic [15:0] ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [1:0]  opIn = 2'd0;
  logic [1:0]  chIn = 2'd0;
  logic [31:0] addIn = 32'd0;

  logic [63:0] accum0;
  logic [15:0] accum1, accum2;
  logic        done0, done1, done2;
  logic        busy0, busy1, busy2;
  logic [3:0]  ovf0, ovf1;
  logic [2:0]  ovf2;

  exp_t        expQ[$];
  int          checks = 0;
  int          failures = 0;
  logic [2:0]  prevDone = 3'b000;

  always #5 clk = ~clk;

  accum_multi u_dut0 (
    .clk(clk), .reset_l(reset_l), .en(en0), .op(opIn), .ch(chIn), .add(addIn),
    .accum(accum0), .done(done0), .busy(busy0), .ovf(ovf0)
  );

  accum_multi #(.ACCUM_WIDTH(16), .ADD_WIDTH(8), .NUM_CH(4), .SATURATE(1)) u_dut1 (
    .clk(clk), .reset_l(reset_l), .en(en1), .op(opIn), .ch(chIn), .add(addIn[7:0]),
    .accum(accum1), .done(done1), .busy(busy1), .ovf(ovf1)
  );

  accum_multi #(.ACCUM_WIDTH(16), .ADD_WIDTH(8), .NUM_CH(3), .SATURATE(0)) u_dut2 (
    .clk(clk), .reset_l(reset_l), .en(en2), .op(opIn), .ch(chIn), .add(addIn[7:0]),
    .accum(accum2), .done(done2), .busy(busy2), .ovf(ovf2)
  );

  function automatic logic getDone(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic getBusy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [63:0] getAccum(input int d);
    case (d)
      0:       return accum0;
      1:       return {48'd0, accum1};
      default: return {48'd0, accum2};
    endcase
  endfunction

  function automatic logic [15:0] getOvf(input int d);
    case (d)
      0:       return {12'd0, ovf0};
      1:       return {12'd0, ovf1};
      default: return {13'd0, ovf2};
    endcase
  endfunction

  task automatic setEn(input int d, input logic v);
    case (d)
      0:       en0 = v;
      1:       en1 = v;
      default: en2 = v;
    endcase
  endtask

  task automatic checkOutput(input int d);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_done dut%0d accum=%h ovf=%h with no request pending",
               d, getAccum(d), getOvf(d));
    end else begin
      e = expQ.pop_front();
      if ((e.dutIdx != d) || (e.accum != getAccum(d)) || (e.ovf != getOvf(d))) begin
        failures++;
        $display("[TB] FAIL result dut%0d accum=%h ovf=%h required dut%0d accum=%h ovf=%h",
                 d, getAccum(d), getOvf(d), e.dutIdx, e.accum, e.ovf);
      end
    end
  endtask

  // Monitor: every rising done on any instance consumes one scoreboard entry.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (getDone(d) && !prevDone[d]) checkOutput(d);
      prevDone[d] = getDone(d);
    end
  end

  task automatic applyStimulus(input int d, input logic [1:0] opV, input logic [1:0] chV,
                               input logic [31:0] addV, input int holdCycles,
                               input logic [63:0] expAccum, input logic [15:0] expOvf);
    int   cyc;
    logic seen;
    expQ.push_back('{dutIdx: d, accum: expAccum, ovf: expOvf});
    opIn  = opV;
    chIn  = chV;
    addIn = addV;
    setEn(d, 1'b1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && (cyc < 10)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (getDone(d)) seen = 1'b1;
      if (cyc == 1) begin
        opIn  = opV ^ 2'b11;
        chIn  = chV ^ 2'b01;
        addIn = ~addV;
      end
    end
    checks++;
    if (!seen || (cyc != 2)) begin
      failures++;
      $display("[TB] FAIL latency dut%0d cycles=%0d seen=%0b required cycles=2 seen=1", d, cyc, seen);
    end
    repeat (holdCycles) begin
      @(negedge clk);
      checks++;
      if (!getDone(d)) begin
        failures++;
        $display("[TB] FAIL done_hold dut%0d done=0 required 1 while en high", d);
      end
    end
    setEn(d, 1'b0);
    @(negedge clk);
    checks++;
    if (getDone(d) || getBusy(d)) begin
      failures++;
      $display("[TB] FAIL release dut%0d done=%0b busy=%0b required 0 0", d, getDone(d), getBusy(d));
    end
  endtask

  task automatic applyShortPulse(input int d, input logic [1:0] opV, input logic [1:0] chV,
                                 input logic [31:0] addV, input logic [63:0] expAccum,
                                 input logic [15:0] expOvf);
    expQ.push_back('{dutIdx: d, accum: expAccum, ovf: expOvf});
    opIn  = opV;
    chIn  = chV;
    addIn = addV;
    setEn(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!getBusy(d) || getDone(d)) begin
      failures++;
      $display("[TB] FAIL exec_state dut%0d busy=%0b done=%0b required 1 0", d, getBusy(d), getDone(d));
    end
    setEn(d, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!getDone(d)) begin
      failures++;
      $display("[TB] FAIL short_done dut%0d done=0 required 1", d);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (getDone(d)) begin
      failures++;
      $display("[TB] FAIL short_done_len dut%0d done=1 required 0 after one cycle", d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitCyc;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ((getAccum(d) != 64'd0) || getDone(d) || getBusy(d) || (getOvf(d) != 16'd0)) begin
        failures++;
        $display("[TB] FAIL reset_state dut%0d accum=%h done=%0b busy=%0b ovf=%h required all 0",
                 d, getAccum(d), getDone(d), getBusy(d), getOvf(d));
      end
    end
    reset_l = 1'b1;

    // Default instance: 64-bit wrap, four channels.
    applyStimulus(0, ADD, 2'd0, 32'h5,        0, 64'h5,        16'h0);
    applyStimulus(0, ADD, 2'd0, 32'h7,        0, 64'hC,        16'h0);
    applyStimulus(0, ADD, 2'd1, 32'hFFFFFFFF, 0, 64'hFFFFFFFF, 16'h0);
    applyStimulus(0, ADD, 2'd2, 32'h1,        0, 64'h1,        16'h0);
    applyStimulus(0, RD,  2'd1, 32'h1234,     0, 64'hFFFFFFFF, 16'h0);
    applyStimulus(0, RD,  2'd0, 32'h0,        0, 64'hC,        16'h0);
    applyStimulus(0, SUB, 2'd0, 32'hD,        0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h1);
    applyStimulus(0, RD,  2'd2, 32'h0,        0, 64'h1,        16'h1);
    applyStimulus(0, ADD, 2'd3, 32'h10,       5, 64'h10,       16'h1);
    applyStimulus(0, RD,  2'd3, 32'h0,        0, 64'h10,       16'h1);
    applyStimulus(0, CLR, 2'd0, 32'hFF,       0, 64'h0,        16'h0);
    applyShortPulse(0, ADD, 2'd3, 32'h2, 64'h12, 16'h0);

    // Clamping instance: climb ch0 to 0xFFF0 in 0xFF steps, then overflow it.
    for (int k = 1; k <= 256; k++) begin
      applyStimulus(1, ADD, 2'd0, 32'hFF, 0, 64'(k * 255), 16'h0);
    end
    applyStimulus(1, ADD, 2'd0, 32'hF0, 0, 64'hFFF0, 16'h0);
    applyStimulus(1, ADD, 2'd0, 32'h20, 0, 64'hFFFF, 16'h1);
    applyStimulus(1, SUB, 2'd3, 32'h1,  0, 64'h0,    16'h9);
    applyStimulus(1, ADD, 2'd1, 32'h3,  0, 64'h3,    16'h9);
    applyStimulus(1, RD,  2'd0, 32'h0,  0, 64'hFFFF, 16'h9);

    // Wrapping instance with three channels; ch3 addresses nothing.
    applyStimulus(2, SUB, 2'd0, 32'h10, 0, 64'hFFF0, 16'h1);
    applyStimulus(2, ADD, 2'd0, 32'h20, 0, 64'h0010, 16'h1);
    applyStimulus(2, ADD, 2'd1, 32'h7,  0, 64'h7,    16'h1);
    applyStimulus(2, ADD, 2'd3, 32'h5,  0, 64'h0,    16'h1);
    applyStimulus(2, RD,  2'd1, 32'h0,  0, 64'h7,    16'h1);
    applyStimulus(2, CLR, 2'd0, 32'h0,  0, 64'h0,    16'h0);
    applyStimulus(2, RD,  2'd0, 32'h0,  0, 64'h0,    16'h0);

    // Reset during EXEC must abort without a done pulse.
    opIn  = ADD;
    chIn  = 2'd1;
    addIn = 32'h99;
    en0   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    checks++;
    if ((accum0 != 64'd0) || done0 || busy0 || (ovf0 != 4'd0)) begin
      failures++;
      $display("[TB] FAIL reset_abort accum=%h done=%0b busy=%0b ovf=%h required all 0",
               accum0, done0, busy0, ovf0);
    end
    en0 = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(0, RD, 2'd1, 32'h0, 0, 64'h0, 16'h0);

    waitCyc = 0;
    while ((expQ.size() != 0) && (waitCyc < 20)) begin
      @(negedge clk);
      waitCyc++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_results outstanding=%0d required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
